bus_alu_seq_ctrl: RTL and testbench
===================================

// Module: bus_alu_seq_ctrl
// PURPOSE
//  Parametrised bus-addressed ALU/shifter. Command = {dispositivo, operacion}; operands arrive serially on
//  one shared data bus; result is returned with a valid/ready handshake. Sits between the bus master
//  (sequencer) and downstream consumers; replaces the fixed 8-bit ALU/shift unit with a handshaked,
//  width-generic, error-reporting version.
// PARAMETERS
//  WIDTH   8    operand/result width in bits (>=2)
//  CNT_W   16   width of completed-operation counter
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  cmd_valid  in   1      command present on dispositivo/operacion
//  cmd_ready  out  1      block accepts a command (IDLE only)
//  dispositivo in  2      device select: 00 ALU, 01 shifter-A, 10 shifter-B, 11 reserved
//  operacion  in   2      operation within device
//  data_valid in   1      operand present on data_in
//  data_ready out  1      high in LOAD_A/LOAD_B
//  data_in    in   WIDTH  operand bus
//  res_valid  out  1      result/flags valid; held until res_ready
//  res_ready  in   1      consumer accepts result
//  result     out  WIDTH  result
//  carry      out  1      carry/borrow/shifted-out bit
//  err        out  1      illegal command flag, qualified by res_valid
//  op_count   out  CNT_W  completed (accepted) results, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE; A,B,result,op_count=0; res_valid,carry,err=0. cmd_ready and
//    data_ready forced 0 while rst=1. Reset mid-operation discards the command; no result is issued.
//  - Code map {dev,op} -> operands, result, carry:
//    0000 A        result=A            carry=0
//    0001 A,B      result=A+B          carry=adder carry-out
//    0010 B        result=B            carry=0
//    0011 A,B      result=A-B          carry=borrow (A<B)
//    0100 A        result=A<<1         carry=A[WIDTH-1]
//    0101 A        result=A>>1 logical carry=A[0]
//    1000 B        result=B<<1         carry=B[WIDTH-1]
//    1001 B        result=B>>1 logical carry=B[0]
//    other         illegal: result=0, carry=0, err=1, no operands consumed
//  - Arithmetic modulo 2^WIDTH. A,B retain values between commands (unused operand not cleared).
//  - FSM: IDLE -> LOAD_A | LOAD_B | RESP(illegal); LOAD_A -> LOAD_B (2-operand) | EXEC;
//    LOAD_B -> EXEC; EXEC -> RESP; RESP -> IDLE on res_ready.
//  - IDLE: cmd_ready=1; command latched on cmd_valid&cmd_ready; dev/op ignored afterwards.
//  - LOAD_x: operand captured on data_valid&data_ready; A always loaded before B. data_valid
//    outside LOAD_x ignored. Waits indefinitely (no timeout).
//  - EXEC: one cycle; result/carry/err registered at its end edge.
//  - Latency: res_valid rises 2 edges after the edge accepting the final operand; illegal command:
//    res_valid 1 edge after command acceptance.
//  - RESP: res_valid=1, result/carry/err stable until res_ready sampled high. Handshake edge:
//    res_valid drops, op_count+1 (illegal commands also counted), state IDLE; next command accepted
//    no earlier than the following edge (max throughput 1 op / 4 cycles for 1-operand codes).
//  - Simultaneous cmd_valid during LOAD/EXEC/RESP: not accepted (cmd_ready=0), master must hold.
// TESTING
//  1 rst 2 cycles -> all outputs 0; release -> cmd_ready=1 next cycle, op_count=0.
//  2 WIDTH=8: cmd 0001, data 8'hF0 then 8'h20 -> result=8'h10, carry=1, err=0, res_valid 2 edges
//    after 2nd operand.
//  3 cmd 0011, A=8'h05, B=8'h07 -> result=8'hFE, carry=1; hold res_ready=0 5 cycles -> result stable,
//    op_count increments only at handshake edge.
//  4 cmd 0101 A=8'h81 -> result=8'h40 carry=1; cmd 1000 B=8'h81 -> result=8'h02 carry=1, A unchanged.
//  5 cmd 1111 -> no data_ready, res_valid next edge with err=1, result=0; op_count increments.
//  6 rst asserted in LOAD_B after A accepted -> no res_valid, IDLE, A=0; op_count preset to
//    2^CNT_W-1 (via run) then one op -> wraps to 0.

Source files
------------

// File: rtl/bus_alu_seq_ctrl.sv
// Bus-addressed ALU/shifter: takes a {dispositivo, operacion} command, then serial operands, returns result/carry/err.
// Latency: result 2 edges after the final operand edge (inclusive); illegal commands respond on the acceptance edge.
// Backpressure: cmd_ready only in IDLE, data_ready only in LOAD_A/LOAD_B; the result is held until res_ready.
//
// Ports:
//   clk, rst                 single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; dispositivo (device) and operacion (op) are the command
//   data_valid/data_ready    operand handshake on data_in; A is always loaded before B
//   res_valid/res_ready      result handshake; result, carry and err qualified by res_valid
//   op_count                 completed result handshakes, wraps to zero
module bus_alu_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       dispositivo,
    input  logic [1:0]       operacion,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [3:0]       code;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] exec_res;
    logic             exec_carry;
    logic [3:0]       cmd_code;

    // Which operands each legal code consumes; a code that uses neither is illegal.
    function automatic logic uses_a(input logic [3:0] c);
        return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0011) ||
               (c == 4'b0100) || (c == 4'b0101);
    endfunction

    function automatic logic uses_b(input logic [3:0] c);
        return (c == 4'b0001) || (c == 4'b0010) || (c == 4'b0011) ||
               (c == 4'b1000) || (c == 4'b1001);
    endfunction

    assign cmd_code   = {dispositivo, operacion};
    // Handshake readies are masked by rst so nothing is accepted on a reset edge.
    assign cmd_ready  = !rst && (state == S_IDLE);
    assign data_ready = !rst && ((state == S_LOAD_A) || (state == S_LOAD_B));

    always_comb begin
        exec_res   = '0;
        exec_carry = 1'b0;
        case (code)
            4'b0000: exec_res = a_reg;
            4'b0001: {exec_carry, exec_res} = {1'b0, a_reg} + {1'b0, b_reg};
            4'b0010: exec_res = b_reg;
            // Top bit of the (WIDTH+1)-bit difference is the borrow (A < B).
            4'b0011: {exec_carry, exec_res} = {1'b0, a_reg} - {1'b0, b_reg};
            4'b0100: {exec_carry, exec_res} = {a_reg, 1'b0};
            4'b0101: begin
                exec_res   = a_reg >> 1;
                exec_carry = a_reg[0];
            end
            4'b1000: {exec_carry, exec_res} = {b_reg, 1'b0};
            4'b1001: begin
                exec_res   = b_reg >> 1;
                exec_carry = b_reg[0];
            end
            default: begin
                exec_res   = '0;
                exec_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            code      <= 4'b0000;
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            carry     <= 1'b0;
            err       <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        code <= cmd_code;
                        if (uses_a(cmd_code)) begin
                            state <= S_LOAD_A;
                        end else if (uses_b(cmd_code)) begin
                            state <= S_LOAD_B;
                        end else begin
                            // Illegal: respond straight away, operands untouched.
                            result    <= '0;
                            carry     <= 1'b0;
                            err       <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end
                end
                S_LOAD_A: begin
                    if (data_valid) begin
                        a_reg <= data_in;
                        state <= uses_b(code) ? S_LOAD_B : S_EXEC;
                    end
                end
                S_LOAD_B: begin
                    if (data_valid) begin
                        b_reg <= data_in;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result    <= exec_res;
                    carry     <= exec_carry;
                    err       <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_ONE;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_alu_seq_ctrl.sv
// Testbench for bus_alu_seq_ctrl: random and directed commands, scoreboard-checked results.
// Latency: n/a (drives the DUT with its own clock).
// Backpressure: res_ready toggles randomly, with an explicit hold-off phase.
module tb_bus_alu_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       dispositivo;
    logic [1:0]       operacion;
    logic             data_valid;
    logic             data_ready;
    logic [WIDTH-1:0] data_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             err;
    logic [CNT_W-1:0] op_count;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   model_a = 0;
    int   model_b = 0;
    int   mon_count = 0;
    logic hold_rdy = 1'b0;

    bus_alu_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .dispositivo(dispositivo), .operacion(operacion),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .carry(carry), .err(err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference model: operand usage and arithmetic straight from the code table.
    function automatic bit needs_a(input logic [3:0] c);
        return c inside {4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101};
    endfunction

    function automatic bit needs_b(input logic [3:0] c);
        return c inside {4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1001};
    endfunction

    function automatic exp_t model(input logic [3:0] c, input int a, input int b);
        int r;
        bit cy;
        bit ill;
        r = 0; cy = 1'b0; ill = 1'b0;
        case (c)
            4'b0000: r = a;
            4'b0001: begin r = a + b; cy = (r >= 256); r = r % 256; end
            4'b0010: r = b;
            4'b0011: begin cy = (a < b); r = (a - b + 256) % 256; end
            4'b0100: begin cy = (a >= 128); r = (a * 2) % 256; end
            4'b0101: begin cy = (a % 2 == 1); r = a / 2; end
            4'b1000: begin cy = (b >= 128); r = (b * 2) % 256; end
            4'b1001: begin cy = (b % 2 == 1); r = b / 2; end
            default: ill = 1'b1;
        endcase
        return '{res: r[WIDTH-1:0], c: cy, e: ill};
    endfunction

    // Consumer: res_ready changes just after the rising edge so the monitor sees a stable value.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            res_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every result handshake pops one expected response.
    always @(negedge clk) begin
        if (rst) begin
            mon_count = 0;
        end else if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result %0h with empty scoreboard", result);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("carry", 32'(carry), 32'(mon_e.c));
                check("err", 32'(err), 32'(mon_e.e));
                check("op_count_at_handshake", 32'(op_count), 32'(mon_count % CNT_MOD));
                mon_count++;
            end
        end
    end

    task automatic send_operand(input logic [WIDTH-1:0] v);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        data_valid = 1'b1;
        data_in    = v;
        n = 0;
        while (!data_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!data_ready) timeout_fail("data_ready");
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data_in    = WIDTH'($urandom);
    endtask

    // Issues one command with its operands; checks latency, optional hold-off, and release.
    task automatic run_op(input logic [3:0] code, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input bit hold);
        int   n;
        exp_t e;
        if (needs_a(code)) model_a = int'(a);
        if (needs_b(code)) model_b = int'(b);
        e = model(code, model_a, model_b);
        exp_q.push_back(e);
        hold_rdy = hold;
        @(negedge clk);
        cmd_valid = 1'b1;
        {dispositivo, operacion} = code;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            timeout_fail("cmd_ready");
            cmd_valid = 1'b0;
            void'(exp_q.pop_back());
            hold_rdy = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        {dispositivo, operacion} = 4'($urandom_range(0, 15));
        if (!(needs_a(code) || needs_b(code))) begin
            check("illegal_res_valid", 32'(res_valid), 32'd1);
            check("illegal_no_data_ready", 32'(data_ready), 32'd0);
        end else begin
            if (needs_a(code)) send_operand(a);
            if (needs_b(code)) send_operand(b);
            // Edge that took the last operand counts as the first; result appears on the second.
            check("res_valid_not_early", 32'(res_valid), 32'd0);
            @(posedge clk);
            #1;
            check("res_valid_latency", 32'(res_valid), 32'd1);
        end
        // Operand bus noise while busy must be ignored.
        data_valid = 1'b1;
        data_in    = WIDTH'($urandom);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("hold_res_valid", 32'(res_valid), 32'd1);
                check("hold_result_stable", 32'(result), 32'(e.res));
                check("hold_op_count", 32'(op_count), 32'(mon_count % CNT_MOD));
            end
            hold_rdy = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            timeout_fail("result_handshake");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        check("res_valid_drop", 32'(res_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0;
        dispositivo = 2'b00;
        operacion = 2'b00;
        data_valid = 1'b0;
        data_in = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_op_count", 32'(op_count), 32'd0);

        // Directed cases.
        run_op(4'b0001, 8'hF0, 8'h20, 1'b0);  // add with carry-out
        run_op(4'b0011, 8'h05, 8'h07, 1'b1);  // subtract with borrow, held result
        run_op(4'b0101, 8'h81, 8'h00, 1'b0);  // A >> 1
        run_op(4'b1000, 8'h00, 8'h81, 1'b0);  // B << 1
        run_op(4'b0000, 8'h81, 8'h00, 1'b0);  // pass A
        run_op(4'b0010, 8'h00, 8'h81, 1'b0);  // pass B, still from the shifter-B load
        run_op(4'b1111, 8'h00, 8'h00, 1'b0);  // illegal
        run_op(4'b0110, 8'h00, 8'h00, 1'b0);  // illegal
        run_op(4'b0100, 8'h7F, 8'h00, 1'b0);  // A << 1, no carry
        run_op(4'b1001, 8'h00, 8'h02, 1'b0);  // B >> 1, no carry

        // Random commands, legal and illegal.
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), WIDTH'($urandom), WIDTH'($urandom),
                   ($urandom_range(0, 7) == 0));
        end

        // Reset while waiting for operand B: command is dropped, A cleared.
        @(negedge clk);
        cmd_valid = 1'b1;
        {dispositivo, operacion} = 4'b0001;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeout_fail("cmd_ready_rst_case");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        send_operand(8'h33);
        check("load_b_data_ready", 32'(data_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_masks_data_ready", 32'(data_ready), 32'd0);
        check("rst_masks_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_a = 0;
        model_b = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_result_after_rst", 32'(res_valid), 32'd0);
        end
        check("op_count_after_rst", 32'(op_count), 32'd0);

        // A reads back as zero; then fill the counter until it wraps.
        run_op(4'b0000, 8'h00, 8'h00, 1'b0);
        for (int i = 1; i < CNT_MOD; i++) begin
            run_op(4'($urandom_range(0, 15)), WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        end
        @(negedge clk);
        check("op_count_wrap", 32'(op_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
